// File: rtl/scalar_issue_fifo.sv
// scalar_issue_fifo: first-word-fall-through issue buffer between the scalar core and the vector pipeline
module scalar_issue_fifo #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_rsc_dat,
    input  logic                  in_rsc_vld,
    output logic                  in_rsc_rdy,
    output logic [DATA_WIDTH-1:0] out_rsc_dat,
    output logic                  out_rsc_vld,
    input  logic                  out_rsc_rdy,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  afull,
    output logic [31:0]           issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign in_rsc_rdy = !flush && (count != CNT_WIDTH'(DEPTH));
    assign out_rsc_vld = !flush && (count != '0);
    assign out_rsc_dat = mem[rd_ptr];
    assign afull = count >= CNT_WIDTH'(AFULL_LEVEL);
    assign push = in_rsc_vld && in_rsc_rdy;
    assign pop = out_rsc_vld && out_rsc_rdy;
    always_ff @(posedge clk)
        if (!rst && push) mem[wr_ptr] <= in_rsc_dat;
    // flush rewinds the pointers only; stored words and issued_cnt survive
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            issued_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            issued_cnt <= issued_cnt + 32'(pop);
        end
    end
endmodule

// File: tb/tb_scalar_issue_fifo.sv
// tb_scalar_issue_fifo: directed and randomized checks of scalar_issue_fifo against a queue model
module tb_scalar_issue_fifo;
    localparam int DW = 96;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic rst = 1;
    logic [DW-1:0] in_rsc_dat = '0;
    logic in_rsc_vld = 0;
    logic in_rsc_rdy;
    logic [DW-1:0] out_rsc_dat;
    logic out_rsc_vld;
    logic out_rsc_rdy = 0;
    logic flush = 0;
    logic [2:0] count;
    logic afull;
    logic [31:0] issued_cnt;
    int checks = 0;
    int errors = 0;
    bit live = 0;
    logic [DW-1:0] q[$];
    logic [31:0] m_issued = 0;

    scalar_issue_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_rsc_dat(in_rsc_dat), .in_rsc_vld(in_rsc_vld), .in_rsc_rdy(in_rsc_rdy),
        .out_rsc_dat(out_rsc_dat), .out_rsc_vld(out_rsc_vld), .out_rsc_rdy(out_rsc_rdy),
        .flush(flush), .count(count), .afull(afull), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: a queue of accepted packets, updated from the handshake rules
    always @(posedge clk) begin
        bit p, o;
        p = in_rsc_vld && !flush && q.size() != DEPTH;
        o = out_rsc_rdy && !flush && q.size() != 0;
        if (rst) begin
            q.delete();
            m_issued = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (o) begin
                void'(q.pop_front());
                m_issued = m_issued + 1;
            end
            if (p) q.push_back(in_rsc_dat);
        end
    end

    always @(negedge clk) if (live) begin
        chk("in_rdy", in_rsc_rdy, !flush && q.size() != DEPTH);
        chk("out_vld", out_rsc_vld, !flush && q.size() != 0);
        if (!flush && q.size() != 0) chk("out_dat", out_rsc_dat, q[0]);
        chk("count", count, q.size());
        chk("afull", afull, q.size() >= DEPTH - 1);
        chk("issued", issued_cnt, m_issued);
    end

    initial begin
        tick();
        tick();
        live = 1;
        rst = 0;
        chk("rst_count", count, 0);
        chk("rst_in_rdy", in_rsc_rdy, 1);
        chk("rst_out_vld", out_rsc_vld, 0);
        chk("rst_afull", afull, 0);
        chk("rst_issued", issued_cnt, 0);

        in_rsc_vld = 1;
        for (int i = 1; i <= 3; i++) begin
            in_rsc_dat = DW'(i);
            tick();
        end
        chk("fill3_count", count, 3);
        chk("fill3_afull", afull, 1);
        chk("fill3_in_rdy", in_rsc_rdy, 1);
        in_rsc_dat = 'h4;
        tick();
        in_rsc_dat = 'h5;
        chk("full_count", count, 4);
        chk("full_in_rdy", in_rsc_rdy, 0);
        tick();
        chk("full_hold_count", count, 4);
        in_rsc_vld = 0;

        out_rsc_rdy = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_dat", out_rsc_dat, DW'(i));
            chk("drain_vld", out_rsc_vld, 1);
            tick();
        end
        out_rsc_rdy = 0;
        chk("drain_count", count, 0);
        chk("drain_issued", issued_cnt, 4);
        chk("drain_out_vld", out_rsc_vld, 0);

        in_rsc_vld = 1;
        out_rsc_rdy = 1;
        in_rsc_dat = 'h10;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("stream_count", count, 1);
            chk("stream_dat", out_rsc_dat, DW'(32'h10 + k - 1));
            in_rsc_dat = DW'(32'h10 + k);
        end
        in_rsc_vld = 0;
        tick();
        out_rsc_rdy = 0;
        chk("stream_issued", issued_cnt, 24);

        in_rsc_vld = 1;
        in_rsc_dat = 'hA0;
        tick();
        in_rsc_dat = 'hA1;
        tick();
        chk("pre_flush_count", count, 2);
        in_rsc_dat = 'hBAD;
        out_rsc_rdy = 1;
        flush = 1;
        #1;
        chk("flush_in_rdy", in_rsc_rdy, 0);
        chk("flush_out_vld", out_rsc_vld, 0);
        tick();
        flush = 0;
        in_rsc_vld = 0;
        out_rsc_rdy = 0;
        chk("post_flush_count", count, 0);
        chk("post_flush_issued", issued_cnt, 24);
        tick();
        chk("flush_drop", count, 0);

        rst = 1;
        tick();
        rst = 0;
        in_rsc_vld = 1;
        out_rsc_rdy = 1;
        for (int i = 0; i < 7; i++) begin
            in_rsc_dat = DW'(i + 'h40);
            tick();
        end
        in_rsc_vld = 0;
        tick();
        out_rsc_rdy = 0;
        in_rsc_vld = 1;
        for (int i = 0; i < 3; i++) begin
            in_rsc_dat = DW'(i + 'h50);
            tick();
        end
        in_rsc_vld = 0;
        chk("pre_rst_count", count, 3);
        chk("pre_rst_issued", issued_cnt, 7);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_issued", issued_cnt, 0);
        chk("mid_rst_out_vld", out_rsc_vld, 0);
        chk("mid_rst_in_rdy", in_rsc_rdy, 1);

        in_rsc_vld = 1;
        in_rsc_dat = 'h60;
        tick();
        in_rsc_dat = 'h61;
        tick();
        in_rsc_vld = 0;
        force dut.issued_cnt = 32'hFFFF_FFFE;
        m_issued = 32'hFFFF_FFFE;
        #1;
        release dut.issued_cnt;
        out_rsc_rdy = 1;
        tick();
        chk("wrap_issued_ff", issued_cnt, 32'hFFFF_FFFF);
        tick();
        out_rsc_rdy = 0;
        chk("wrap_issued_0", issued_cnt, 0);

        for (int c = 0; c < 10000; c++) begin
            in_rsc_vld = ($urandom % 4) != 0;
            out_rsc_rdy = ($urandom % 3) != 0;
            flush = ($urandom % 64) == 0;
            rst = ($urandom % 2000) == 0;
            in_rsc_dat = {$urandom, $urandom, $urandom};
            tick();
        end
        rst = 0;
        flush = 0;
        in_rsc_vld = 0;
        out_rsc_rdy = 0;
        tick();
        live = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
